// File: rtl/mvu_cfg_pkg.sv
// Shared sizes, CSR offset map and field positions for the MVU configuration registers.
package mvu_cfg_pkg;

    localparam int NMVU           = 8;
    localparam int BMVUA          = 3;
    localparam int APB_ADDR_WIDTH = BMVUA + 12;
    localparam int APB_DATA_WIDTH = 32;
    localparam int NJUMPS         = 5;
    localparam int NLEN           = 4;
    localparam int BBWADDR        = 9;
    localparam int BBDADDR        = 9;
    localparam int BSBANKA        = 6;
    localparam int BBBANKA        = 6;
    localparam int BJUMP          = 15;
    localparam int BLENGTH        = 15;
    localparam int BPREC          = 6;
    localparam int BCNTDWN        = 29;
    localparam int BQMSBIDX       = 5;
    localparam int BSCALERB       = 16;

    localparam int PREC_W_LSB     = 0;
    localparam int PREC_I_LSB     = 6;
    localparam int PREC_O_LSB     = 12;
    localparam int PREC_WSIGN     = 24;
    localparam int PREC_DSIGN     = 25;
    localparam int CMD_CNT_LSB    = 0;
    localparam int CMD_MAXEN      = 29;
    localparam int CMD_MUL_LSB    = 30;
    localparam int CFG1_SHACC_LSB = 0;
    localparam int CFG1_ZZ_LSB    = 5;

    typedef enum logic [11:0] {
        CSR_WBASEPTR = 12'h000, CSR_IBASEPTR, CSR_SBASEPTR, CSR_BBASEPTR, CSR_OBASEPTR,
        CSR_WJUMP0 = 12'h005, CSR_WJUMP1, CSR_WJUMP2, CSR_WJUMP3, CSR_WJUMP4,
        CSR_IJUMP0 = 12'h00A, CSR_IJUMP1, CSR_IJUMP2, CSR_IJUMP3, CSR_IJUMP4,
        CSR_SJUMP0 = 12'h00F, CSR_SJUMP1, CSR_SJUMP2, CSR_SJUMP3, CSR_SJUMP4,
        CSR_BJUMP0 = 12'h014, CSR_BJUMP1, CSR_BJUMP2, CSR_BJUMP3, CSR_BJUMP4,
        CSR_OJUMP0 = 12'h019, CSR_OJUMP1, CSR_OJUMP2, CSR_OJUMP3, CSR_OJUMP4,
        CSR_WLENGTH1 = 12'h01E, CSR_WLENGTH2, CSR_WLENGTH3, CSR_WLENGTH4,
        CSR_ILENGTH1 = 12'h022, CSR_ILENGTH2, CSR_ILENGTH3, CSR_ILENGTH4,
        CSR_SLENGTH1 = 12'h026, CSR_SLENGTH2, CSR_SLENGTH3, CSR_SLENGTH4,
        CSR_BLENGTH1 = 12'h02A, CSR_BLENGTH2, CSR_BLENGTH3, CSR_BLENGTH4,
        CSR_OLENGTH1 = 12'h02E, CSR_OLENGTH2, CSR_OLENGTH3, CSR_OLENGTH4,
        CSR_PRECISION = 12'h032, CSR_STATUS, CSR_COMMAND, CSR_QUANT, CSR_SCALER, CSR_CONFIG1,
        CSR_OMVUSEL = 12'h038, CSR_IHPBASEADDR, CSR_OHPBASEADDR, CSR_OHPMVUSEL,
        CSR_HPJUMP0 = 12'h03C, CSR_HPJUMP1, CSR_HPJUMP2, CSR_HPJUMP3, CSR_HPJUMP4,
        CSR_HPLENGTH1 = 12'h041, CSR_HPLENGTH2, CSR_HPLENGTH3, CSR_HPLENGTH4,
        CSR_USESCALER_MEM = 12'h045, CSR_USEBIAS_MEM, CSR_USEPOOLER4HPOUT, CSR_USEHPADDER
    } mvu_csr_t;

    typedef enum logic [4:0] {
        G_NONE, G_WBASE, G_IBASE, G_SBASE, G_BBASE, G_OBASE,
        G_WJUMP, G_IJUMP, G_SJUMP, G_BJUMP, G_OJUMP, G_HPJUMP,
        G_WLEN, G_ILEN, G_SLEN, G_BLEN, G_OLEN, G_HPLEN,
        G_PREC, G_STATUS, G_CMD, G_QUANT, G_SCALER, G_CFG1,
        G_OMVUSEL, G_IHPBASE, G_OHPBASE, G_OHPSEL,
        G_USESC, G_USEBIAS, G_USEPOOL, G_USEHPADD
    } csr_grp_t;

    typedef struct packed {
        csr_grp_t   grp;
        logic [2:0] idx;
    } csr_dec_t;

    typedef logic [NJUMPS-1:0][BJUMP-1:0] jumps_t;
    typedef logic [NLEN-1:0][BLENGTH-1:0] lens_t;

    // Collapses the flat offset map into a register group plus the slot within the group.
    function automatic csr_dec_t csr_decode(input logic [11:0] off);
        csr_dec_t d;
        d.grp = G_NONE;
        d.idx = '0;
        case (off) inside
            CSR_WBASEPTR:                   d.grp = G_WBASE;
            CSR_IBASEPTR:                   d.grp = G_IBASE;
            CSR_SBASEPTR:                   d.grp = G_SBASE;
            CSR_BBASEPTR:                   d.grp = G_BBASE;
            CSR_OBASEPTR:                   d.grp = G_OBASE;
            [CSR_WJUMP0:CSR_WJUMP4]:        begin d.grp = G_WJUMP;  d.idx = 3'(off - CSR_WJUMP0);    end
            [CSR_IJUMP0:CSR_IJUMP4]:        begin d.grp = G_IJUMP;  d.idx = 3'(off - CSR_IJUMP0);    end
            [CSR_SJUMP0:CSR_SJUMP4]:        begin d.grp = G_SJUMP;  d.idx = 3'(off - CSR_SJUMP0);    end
            [CSR_BJUMP0:CSR_BJUMP4]:        begin d.grp = G_BJUMP;  d.idx = 3'(off - CSR_BJUMP0);    end
            [CSR_OJUMP0:CSR_OJUMP4]:        begin d.grp = G_OJUMP;  d.idx = 3'(off - CSR_OJUMP0);    end
            [CSR_HPJUMP0:CSR_HPJUMP4]:      begin d.grp = G_HPJUMP; d.idx = 3'(off - CSR_HPJUMP0);   end
            [CSR_WLENGTH1:CSR_WLENGTH4]:    begin d.grp = G_WLEN;   d.idx = 3'(off - CSR_WLENGTH1);  end
            [CSR_ILENGTH1:CSR_ILENGTH4]:    begin d.grp = G_ILEN;   d.idx = 3'(off - CSR_ILENGTH1);  end
            [CSR_SLENGTH1:CSR_SLENGTH4]:    begin d.grp = G_SLEN;   d.idx = 3'(off - CSR_SLENGTH1);  end
            [CSR_BLENGTH1:CSR_BLENGTH4]:    begin d.grp = G_BLEN;   d.idx = 3'(off - CSR_BLENGTH1);  end
            [CSR_OLENGTH1:CSR_OLENGTH4]:    begin d.grp = G_OLEN;   d.idx = 3'(off - CSR_OLENGTH1);  end
            [CSR_HPLENGTH1:CSR_HPLENGTH4]:  begin d.grp = G_HPLEN;  d.idx = 3'(off - CSR_HPLENGTH1); end
            CSR_PRECISION:                  d.grp = G_PREC;
            CSR_STATUS:                     d.grp = G_STATUS;
            CSR_COMMAND:                    d.grp = G_CMD;
            CSR_QUANT:                      d.grp = G_QUANT;
            CSR_SCALER:                     d.grp = G_SCALER;
            CSR_CONFIG1:                    d.grp = G_CFG1;
            CSR_OMVUSEL:                    d.grp = G_OMVUSEL;
            CSR_IHPBASEADDR:                d.grp = G_IHPBASE;
            CSR_OHPBASEADDR:                d.grp = G_OHPBASE;
            CSR_OHPMVUSEL:                  d.grp = G_OHPSEL;
            CSR_USESCALER_MEM:              d.grp = G_USESC;
            CSR_USEBIAS_MEM:                d.grp = G_USEBIAS;
            CSR_USEPOOLER4HPOUT:            d.grp = G_USEPOOL;
            CSR_USEHPADDER:                 d.grp = G_USEHPADD;
            default:                        d.grp = G_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mvu_apb_cfg_regs_if.sv
// APB bus bundle for the MVU CSR block; MVU_CSR_READBACK_EN adds the prdata return path.
interface mvu_apb_cfg_regs_if;
    import mvu_cfg_pkg::*;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pready;
    logic                      pslverr;
`ifdef MVU_CSR_READBACK_EN
    logic [APB_DATA_WIDTH-1:0] prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata, input pready, pslverr, prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, pslverr, prdata);
`else
    modport master (output psel, penable, pwrite, paddr, pwdata, input pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, pslverr);
`endif

endinterface

// File: rtl/mvu_start_gen.sv
// One-cycle per-MVU start pulse on COMMAND writes; a write landing while start is high is replayed once it drops.
module mvu_start_gen
    import mvu_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_wr,
    input  logic [BMVUA-1:0] mvu_id,
    output logic [NMVU-1:0]  start
);

    logic [NMVU-1:0] hit;
    logic [NMVU-1:0] pend_q;

    always_comb begin
        hit = '0;
        if (cmd_wr) hit[mvu_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start  <= '0;
            pend_q <= '0;
        end else begin
            start  <= (hit | pend_q) & ~start;
            pend_q <= hit & start;
        end
    end

endmodule

// File: rtl/mvu_apb_cfg_regs.sv
// Write-only, zero-wait APB CSR block holding the per-MVU configuration and start pulses.
// Optional MVU_CSR_READBACK_EN adds combinational prdata readback.
module mvu_apb_cfg_regs
    import mvu_cfg_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    mvu_apb_cfg_regs_if.slave           apb,
    output logic [NMVU-1:0]             start,
    output logic [NMVU*BBWADDR-1:0]     cfg_wbaseaddr,
    output logic [NMVU*BBDADDR-1:0]     cfg_ibaseaddr,
    output logic [NMVU*BBDADDR-1:0]     cfg_obaseaddr,
    output logic [NMVU*BBDADDR-1:0]     cfg_ihpbaseaddr,
    output logic [NMVU*BBDADDR-1:0]     cfg_ohpbaseaddr,
    output logic [NMVU*BSBANKA-1:0]     cfg_sbaseaddr,
    output logic [NMVU*BBBANKA-1:0]     cfg_bbaseaddr,
    output logic [NMVU*NJUMPS*BJUMP-1:0] cfg_wjump,
    output logic [NMVU*NJUMPS*BJUMP-1:0] cfg_ijump,
    output logic [NMVU*NJUMPS*BJUMP-1:0] cfg_sjump,
    output logic [NMVU*NJUMPS*BJUMP-1:0] cfg_bjump,
    output logic [NMVU*NJUMPS*BJUMP-1:0] cfg_ojump,
    output logic [NMVU*NJUMPS*BJUMP-1:0] cfg_hpjump,
    output logic [NMVU*NLEN*BLENGTH-1:0] cfg_wlength,
    output logic [NMVU*NLEN*BLENGTH-1:0] cfg_ilength,
    output logic [NMVU*NLEN*BLENGTH-1:0] cfg_slength,
    output logic [NMVU*NLEN*BLENGTH-1:0] cfg_blength,
    output logic [NMVU*NLEN*BLENGTH-1:0] cfg_olength,
    output logic [NMVU*NLEN*BLENGTH-1:0] cfg_hplength,
    output logic [NMVU*BPREC-1:0]       cfg_wprecision,
    output logic [NMVU*BPREC-1:0]       cfg_iprecision,
    output logic [NMVU*BPREC-1:0]       cfg_oprecision,
    output logic [NMVU-1:0]             cfg_w_signed,
    output logic [NMVU-1:0]             cfg_d_signed,
    output logic [NMVU*BCNTDWN-1:0]     cfg_countdown,
    output logic [NMVU-1:0]             cfg_max_en,
    output logic [NMVU*2-1:0]           cfg_mul_mode,
    output logic [NMVU-1:0]             cfg_max_clr,
    output logic [NMVU-1:0]             cfg_max_pool,
    output logic [NMVU-1:0]             cfg_quant_clr,
    output logic [NMVU*BQMSBIDX-1:0]    cfg_quant_msbidx,
    output logic [NMVU*BSCALERB-1:0]    cfg_scaler_b,
    output logic [NMVU*NJUMPS-1:0]      cfg_shacc_load_sel,
    output logic [NMVU*NJUMPS-1:0]      cfg_zigzag_step_sel,
    output logic [NMVU*NMVU-1:0]        cfg_omvusel,
    output logic [NMVU-1:0]             cfg_ohpmvusel,
    output logic [NMVU-1:0]             cfg_usescaler_mem,
    output logic [NMVU-1:0]             cfg_usebias_mem,
    output logic [NMVU-1:0]             cfg_usepooler4hpout,
    output logic [NMVU-1:0]             cfg_usehpadder
);

    logic [BMVUA-1:0] id;
    logic             id_ok;
    logic             wr;
    csr_dec_t         dec;

    logic [BBWADDR-1:0]  wbase_q [NMVU];
    logic [BBDADDR-1:0]  ibase_q [NMVU], obase_q [NMVU], ihpbase_q [NMVU], ohpbase_q [NMVU];
    logic [BSBANKA-1:0]  sbase_q [NMVU];
    logic [BBBANKA-1:0]  bbase_q [NMVU];
    jumps_t              wjump_q [NMVU], ijump_q [NMVU], sjump_q [NMVU];
    jumps_t              bjump_q [NMVU], ojump_q [NMVU], hpjump_q [NMVU];
    lens_t               wlen_q [NMVU], ilen_q [NMVU], slen_q [NMVU];
    lens_t               blen_q [NMVU], olen_q [NMVU], hplen_q [NMVU];
    logic [BPREC-1:0]    wprec_q [NMVU], iprec_q [NMVU], oprec_q [NMVU];
    logic [BCNTDWN-1:0]  cnt_q [NMVU];
    logic [1:0]          mul_q [NMVU];
    logic [BQMSBIDX-1:0] qmsb_q [NMVU];
    logic [BSCALERB-1:0] scb_q [NMVU];
    logic [NJUMPS-1:0]   shacc_q [NMVU], zz_q [NMVU];
    logic [NMVU-1:0]     omvusel_q [NMVU];
    logic [NMVU-1:0]     wsgn_q, dsgn_q, maxen_q, ohpsel_q, usesc_q, usebias_q, usepool_q, usehpadd_q;

    assign id  = apb.paddr[APB_ADDR_WIDTH-1:12];
    assign dec = csr_decode(apb.paddr[11:0]);

    // With a fully populated index space every id is a real MVU.
    if (NMVU < 2**BMVUA) begin : g_id_chk
        assign id_ok = (id < BMVUA'(NMVU));
    end else begin : g_id_all
        assign id_ok = 1'b1;
    end

    assign wr          = apb.psel & apb.penable & apb.pwrite & id_ok;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbase_q <= '{default: '0}; ibase_q <= '{default: '0}; obase_q <= '{default: '0};
            ihpbase_q <= '{default: '0}; ohpbase_q <= '{default: '0};
            sbase_q <= '{default: '0}; bbase_q <= '{default: '0};
            wjump_q <= '{default: '0}; ijump_q <= '{default: '0}; sjump_q <= '{default: '0};
            bjump_q <= '{default: '0}; ojump_q <= '{default: '0}; hpjump_q <= '{default: '0};
            wlen_q <= '{default: '0}; ilen_q <= '{default: '0}; slen_q <= '{default: '0};
            blen_q <= '{default: '0}; olen_q <= '{default: '0}; hplen_q <= '{default: '0};
            wprec_q <= '{default: '0}; iprec_q <= '{default: '0}; oprec_q <= '{default: '0};
            cnt_q <= '{default: '0}; mul_q <= '{default: '0}; qmsb_q <= '{default: '0};
            scb_q <= '{default: '0}; shacc_q <= '{default: '0}; zz_q <= '{default: '0};
            omvusel_q <= '{default: '0};
            wsgn_q <= '0; dsgn_q <= '0; maxen_q <= '0; ohpsel_q <= '0;
            usesc_q <= '0; usebias_q <= '0; usepool_q <= '0; usehpadd_q <= '0;
        end else if (wr) begin
            case (dec.grp)
                G_WBASE:    wbase_q[id]   <= apb.pwdata[BBWADDR-1:0];
                G_IBASE:    ibase_q[id]   <= apb.pwdata[BBDADDR-1:0];
                G_SBASE:    sbase_q[id]   <= apb.pwdata[BSBANKA-1:0];
                G_BBASE:    bbase_q[id]   <= apb.pwdata[BBBANKA-1:0];
                G_OBASE:    obase_q[id]   <= apb.pwdata[BBDADDR-1:0];
                G_IHPBASE:  ihpbase_q[id] <= apb.pwdata[BBDADDR-1:0];
                G_OHPBASE:  ohpbase_q[id] <= apb.pwdata[BBDADDR-1:0];
                G_WJUMP:    wjump_q[id][dec.idx]  <= apb.pwdata[BJUMP-1:0];
                G_IJUMP:    ijump_q[id][dec.idx]  <= apb.pwdata[BJUMP-1:0];
                G_SJUMP:    sjump_q[id][dec.idx]  <= apb.pwdata[BJUMP-1:0];
                G_BJUMP:    bjump_q[id][dec.idx]  <= apb.pwdata[BJUMP-1:0];
                G_OJUMP:    ojump_q[id][dec.idx]  <= apb.pwdata[BJUMP-1:0];
                G_HPJUMP:   hpjump_q[id][dec.idx] <= apb.pwdata[BJUMP-1:0];
                G_WLEN:     wlen_q[id][dec.idx[1:0]]  <= apb.pwdata[BLENGTH-1:0];
                G_ILEN:     ilen_q[id][dec.idx[1:0]]  <= apb.pwdata[BLENGTH-1:0];
                G_SLEN:     slen_q[id][dec.idx[1:0]]  <= apb.pwdata[BLENGTH-1:0];
                G_BLEN:     blen_q[id][dec.idx[1:0]]  <= apb.pwdata[BLENGTH-1:0];
                G_OLEN:     olen_q[id][dec.idx[1:0]]  <= apb.pwdata[BLENGTH-1:0];
                G_HPLEN:    hplen_q[id][dec.idx[1:0]] <= apb.pwdata[BLENGTH-1:0];
                G_PREC: begin
                    wprec_q[id] <= apb.pwdata[PREC_W_LSB +: BPREC];
                    iprec_q[id] <= apb.pwdata[PREC_I_LSB +: BPREC];
                    oprec_q[id] <= apb.pwdata[PREC_O_LSB +: BPREC];
                    wsgn_q[id]  <= apb.pwdata[PREC_WSIGN];
                    dsgn_q[id]  <= apb.pwdata[PREC_DSIGN];
                end
                G_CMD: begin
                    cnt_q[id]   <= apb.pwdata[CMD_CNT_LSB +: BCNTDWN];
                    maxen_q[id] <= apb.pwdata[CMD_MAXEN];
                    mul_q[id]   <= apb.pwdata[CMD_MUL_LSB +: 2];
                end
                G_CFG1: begin
                    shacc_q[id] <= apb.pwdata[CFG1_SHACC_LSB +: NJUMPS];
                    zz_q[id]    <= apb.pwdata[CFG1_ZZ_LSB +: NJUMPS];
                end
                G_QUANT:    qmsb_q[id]     <= apb.pwdata[BQMSBIDX-1:0];
                G_SCALER:   scb_q[id]      <= apb.pwdata[BSCALERB-1:0];
                G_OMVUSEL:  omvusel_q[id]  <= apb.pwdata[NMVU-1:0];
                G_OHPSEL:   ohpsel_q[id]   <= apb.pwdata[0];
                G_USESC:    usesc_q[id]    <= apb.pwdata[0];
                G_USEBIAS:  usebias_q[id]  <= apb.pwdata[0];
                G_USEPOOL:  usepool_q[id]  <= apb.pwdata[0];
                G_USEHPADD: usehpadd_q[id] <= apb.pwdata[0];
                default: ;
            endcase
        end
    end

    mvu_start_gen u_start_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd_wr (wr && (dec.grp == G_CMD)),
        .mvu_id (id),
        .start  (start)
    );

    for (genvar g = 0; g < NMVU; g++) begin : g_flat
        assign cfg_wbaseaddr[g*BBWADDR +: BBWADDR]         = wbase_q[g];
        assign cfg_ibaseaddr[g*BBDADDR +: BBDADDR]         = ibase_q[g];
        assign cfg_obaseaddr[g*BBDADDR +: BBDADDR]         = obase_q[g];
        assign cfg_ihpbaseaddr[g*BBDADDR +: BBDADDR]       = ihpbase_q[g];
        assign cfg_ohpbaseaddr[g*BBDADDR +: BBDADDR]       = ohpbase_q[g];
        assign cfg_sbaseaddr[g*BSBANKA +: BSBANKA]         = sbase_q[g];
        assign cfg_bbaseaddr[g*BBBANKA +: BBBANKA]         = bbase_q[g];
        assign cfg_wjump[g*NJUMPS*BJUMP +: NJUMPS*BJUMP]   = wjump_q[g];
        assign cfg_ijump[g*NJUMPS*BJUMP +: NJUMPS*BJUMP]   = ijump_q[g];
        assign cfg_sjump[g*NJUMPS*BJUMP +: NJUMPS*BJUMP]   = sjump_q[g];
        assign cfg_bjump[g*NJUMPS*BJUMP +: NJUMPS*BJUMP]   = bjump_q[g];
        assign cfg_ojump[g*NJUMPS*BJUMP +: NJUMPS*BJUMP]   = ojump_q[g];
        assign cfg_hpjump[g*NJUMPS*BJUMP +: NJUMPS*BJUMP]  = hpjump_q[g];
        assign cfg_wlength[g*NLEN*BLENGTH +: NLEN*BLENGTH] = wlen_q[g];
        assign cfg_ilength[g*NLEN*BLENGTH +: NLEN*BLENGTH] = ilen_q[g];
        assign cfg_slength[g*NLEN*BLENGTH +: NLEN*BLENGTH] = slen_q[g];
        assign cfg_blength[g*NLEN*BLENGTH +: NLEN*BLENGTH] = blen_q[g];
        assign cfg_olength[g*NLEN*BLENGTH +: NLEN*BLENGTH] = olen_q[g];
        assign cfg_hplength[g*NLEN*BLENGTH +: NLEN*BLENGTH] = hplen_q[g];
        assign cfg_wprecision[g*BPREC +: BPREC]            = wprec_q[g];
        assign cfg_iprecision[g*BPREC +: BPREC]            = iprec_q[g];
        assign cfg_oprecision[g*BPREC +: BPREC]            = oprec_q[g];
        assign cfg_countdown[g*BCNTDWN +: BCNTDWN]         = cnt_q[g];
        assign cfg_mul_mode[g*2 +: 2]                      = mul_q[g];
        assign cfg_quant_msbidx[g*BQMSBIDX +: BQMSBIDX]    = qmsb_q[g];
        assign cfg_scaler_b[g*BSCALERB +: BSCALERB]        = scb_q[g];
        assign cfg_shacc_load_sel[g*NJUMPS +: NJUMPS]      = shacc_q[g];
        assign cfg_zigzag_step_sel[g*NJUMPS +: NJUMPS]     = zz_q[g];
        assign cfg_omvusel[g*NMVU +: NMVU]                 = omvusel_q[g];
    end

    assign cfg_w_signed        = wsgn_q;
    assign cfg_d_signed        = dsgn_q;
    assign cfg_max_en          = maxen_q;
    assign cfg_ohpmvusel       = ohpsel_q;
    assign cfg_usescaler_mem   = usesc_q;
    assign cfg_usebias_mem     = usebias_q;
    assign cfg_usepooler4hpout = usepool_q;
    assign cfg_usehpadder      = usehpadd_q;
    assign cfg_max_clr         = '0;
    assign cfg_max_pool        = '0;
    assign cfg_quant_clr       = '0;

`ifdef MVU_CSR_READBACK_EN
    always_comb begin
        apb.prdata = '0;
        if (apb.psel && !apb.pwrite && id_ok) begin
            case (dec.grp)
                G_WBASE:    apb.prdata = 32'(wbase_q[id]);
                G_IBASE:    apb.prdata = 32'(ibase_q[id]);
                G_SBASE:    apb.prdata = 32'(sbase_q[id]);
                G_BBASE:    apb.prdata = 32'(bbase_q[id]);
                G_OBASE:    apb.prdata = 32'(obase_q[id]);
                G_IHPBASE:  apb.prdata = 32'(ihpbase_q[id]);
                G_OHPBASE:  apb.prdata = 32'(ohpbase_q[id]);
                G_WJUMP:    apb.prdata = 32'(wjump_q[id][dec.idx]);
                G_IJUMP:    apb.prdata = 32'(ijump_q[id][dec.idx]);
                G_SJUMP:    apb.prdata = 32'(sjump_q[id][dec.idx]);
                G_BJUMP:    apb.prdata = 32'(bjump_q[id][dec.idx]);
                G_OJUMP:    apb.prdata = 32'(ojump_q[id][dec.idx]);
                G_HPJUMP:   apb.prdata = 32'(hpjump_q[id][dec.idx]);
                G_WLEN:     apb.prdata = 32'(wlen_q[id][dec.idx[1:0]]);
                G_ILEN:     apb.prdata = 32'(ilen_q[id][dec.idx[1:0]]);
                G_SLEN:     apb.prdata = 32'(slen_q[id][dec.idx[1:0]]);
                G_BLEN:     apb.prdata = 32'(blen_q[id][dec.idx[1:0]]);
                G_OLEN:     apb.prdata = 32'(olen_q[id][dec.idx[1:0]]);
                G_HPLEN:    apb.prdata = 32'(hplen_q[id][dec.idx[1:0]]);
                G_PREC:     apb.prdata = {6'b0, dsgn_q[id], wsgn_q[id], 6'b0,
                                          oprec_q[id], iprec_q[id], wprec_q[id]};
                G_STATUS:   apb.prdata = 32'(start[id]);
                G_CMD:      apb.prdata = {mul_q[id], maxen_q[id], cnt_q[id]};
                G_CFG1:     apb.prdata = 32'({zz_q[id], shacc_q[id]});
                G_QUANT:    apb.prdata = 32'(qmsb_q[id]);
                G_SCALER:   apb.prdata = 32'(scb_q[id]);
                G_OMVUSEL:  apb.prdata = 32'(omvusel_q[id]);
                G_OHPSEL:   apb.prdata = 32'(ohpsel_q[id]);
                G_USESC:    apb.prdata = 32'(usesc_q[id]);
                G_USEBIAS:  apb.prdata = 32'(usebias_q[id]);
                G_USEPOOL:  apb.prdata = 32'(usepool_q[id]);
                G_USEHPADD: apb.prdata = 32'(usehpadd_q[id]);
                default:    apb.prdata = '0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mvu_apb_cfg_regs.sv
// Random APB writes against a per-MVU CSR word memory; every output field is re-extracted from that memory.
module tb_mvu_apb_cfg_regs;
    import mvu_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mvu_apb_cfg_regs_if apb ();

    logic [NMVU-1:0]              start;
    logic [NMVU*BBWADDR-1:0]      wbase;
    logic [NMVU*BBDADDR-1:0]      ibase, obase, ihpbase, ohpbase;
    logic [NMVU*BSBANKA-1:0]      sbase;
    logic [NMVU*BBBANKA-1:0]      bbase;
    logic [NMVU*NJUMPS*BJUMP-1:0] wjump, ijump, sjump, bjump, ojump, hpjump;
    logic [NMVU*NLEN*BLENGTH-1:0] wlen, ilen, slen, blen, olen, hplen;
    logic [NMVU*BPREC-1:0]        wprec, iprec, oprec;
    logic [NMVU-1:0]              wsgn, dsgn, maxen, maxclr, maxpool, qclr;
    logic [NMVU*BCNTDWN-1:0]      cntdn;
    logic [NMVU*2-1:0]            mulmode;
    logic [NMVU*BQMSBIDX-1:0]     qmsb;
    logic [NMVU*BSCALERB-1:0]     scb;
    logic [NMVU*NJUMPS-1:0]       shacc, zz;
    logic [NMVU*NMVU-1:0]         omvusel;
    logic [NMVU-1:0]              ohpsel, usesc, usebias, usepool, usehpadd;

    mvu_apb_cfg_regs dut (
        .clk(clk), .rst_n(rst_n), .apb(apb), .start(start),
        .cfg_wbaseaddr(wbase), .cfg_ibaseaddr(ibase), .cfg_obaseaddr(obase),
        .cfg_ihpbaseaddr(ihpbase), .cfg_ohpbaseaddr(ohpbase),
        .cfg_sbaseaddr(sbase), .cfg_bbaseaddr(bbase),
        .cfg_wjump(wjump), .cfg_ijump(ijump), .cfg_sjump(sjump),
        .cfg_bjump(bjump), .cfg_ojump(ojump), .cfg_hpjump(hpjump),
        .cfg_wlength(wlen), .cfg_ilength(ilen), .cfg_slength(slen),
        .cfg_blength(blen), .cfg_olength(olen), .cfg_hplength(hplen),
        .cfg_wprecision(wprec), .cfg_iprecision(iprec), .cfg_oprecision(oprec),
        .cfg_w_signed(wsgn), .cfg_d_signed(dsgn),
        .cfg_countdown(cntdn), .cfg_max_en(maxen), .cfg_mul_mode(mulmode),
        .cfg_max_clr(maxclr), .cfg_max_pool(maxpool), .cfg_quant_clr(qclr),
        .cfg_quant_msbidx(qmsb), .cfg_scaler_b(scb),
        .cfg_shacc_load_sel(shacc), .cfg_zigzag_step_sel(zz),
        .cfg_omvusel(omvusel), .cfg_ohpmvusel(ohpsel),
        .cfg_usescaler_mem(usesc), .cfg_usebias_mem(usebias),
        .cfg_usepooler4hpout(usepool), .cfg_usehpadder(usehpadd)
    );

    int n_vec = 0;
    int n_err = 0;

    // Last word written to each (MVU, offset); fields are sliced out of these words.
    logic [31:0] csr [NMVU][73];

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NMVU; i++)
            for (int k = 0; k < 73; k++) csr[i][k] = '0;
    endtask

    task automatic model_write(input int id, input int off, input logic [31:0] data);
        if (id < NMVU && off <= 72 && off != 51) csr[id][off] = data;
    endtask

    // n consecutive offsets per MVU, each contributing w bits starting at bit lsb of its word.
    function automatic logic [639:0] ex(input int off, input int n, input int w, input int lsb);
        logic [639:0] r = '0;
        for (int i = 0; i < NMVU; i++)
            for (int k = 0; k < n; k++)
                for (int b = 0; b < w; b++)
                    r[(i*n + k)*w + b] = csr[i][off + k][lsb + b];
        return r;
    endfunction

    task automatic check_all();
        chk("wbase",    640'(wbase),    ex(0, 1, 9, 0));
        chk("ibase",    640'(ibase),    ex(1, 1, 9, 0));
        chk("sbase",    640'(sbase),    ex(2, 1, 6, 0));
        chk("bbase",    640'(bbase),    ex(3, 1, 6, 0));
        chk("obase",    640'(obase),    ex(4, 1, 9, 0));
        chk("wjump",    640'(wjump),    ex(5, 5, 15, 0));
        chk("ijump",    640'(ijump),    ex(10, 5, 15, 0));
        chk("sjump",    640'(sjump),    ex(15, 5, 15, 0));
        chk("bjump",    640'(bjump),    ex(20, 5, 15, 0));
        chk("ojump",    640'(ojump),    ex(25, 5, 15, 0));
        chk("wlen",     640'(wlen),     ex(30, 4, 15, 0));
        chk("ilen",     640'(ilen),     ex(34, 4, 15, 0));
        chk("slen",     640'(slen),     ex(38, 4, 15, 0));
        chk("blen",     640'(blen),     ex(42, 4, 15, 0));
        chk("olen",     640'(olen),     ex(46, 4, 15, 0));
        chk("wprec",    640'(wprec),    ex(50, 1, 6, 0));
        chk("iprec",    640'(iprec),    ex(50, 1, 6, 6));
        chk("oprec",    640'(oprec),    ex(50, 1, 6, 12));
        chk("w_signed", 640'(wsgn),     ex(50, 1, 1, 24));
        chk("d_signed", 640'(dsgn),     ex(50, 1, 1, 25));
        chk("countdown",640'(cntdn),    ex(52, 1, 29, 0));
        chk("max_en",   640'(maxen),    ex(52, 1, 1, 29));
        chk("mul_mode", 640'(mulmode),  ex(52, 1, 2, 30));
        chk("quant",    640'(qmsb),     ex(53, 1, 5, 0));
        chk("scaler",   640'(scb),      ex(54, 1, 16, 0));
        chk("shacc",    640'(shacc),    ex(55, 1, 5, 0));
        chk("zigzag",   640'(zz),       ex(55, 1, 5, 5));
        chk("omvusel",  640'(omvusel),  ex(56, 1, 8, 0));
        chk("ihpbase",  640'(ihpbase),  ex(57, 1, 9, 0));
        chk("ohpbase",  640'(ohpbase),  ex(58, 1, 9, 0));
        chk("ohpsel",   640'(ohpsel),   ex(59, 1, 1, 0));
        chk("hpjump",   640'(hpjump),   ex(60, 5, 15, 0));
        chk("hplen",    640'(hplen),    ex(65, 4, 15, 0));
        chk("usesc",    640'(usesc),    ex(69, 1, 1, 0));
        chk("usebias",  640'(usebias),  ex(70, 1, 1, 0));
        chk("usepool",  640'(usepool),  ex(71, 1, 1, 0));
        chk("usehpadd", 640'(usehpadd), ex(72, 1, 1, 0));
        chk("max_clr",  640'(maxclr),   640'(0));
        chk("max_pool", 640'(maxpool),  640'(0));
        chk("quant_clr",640'(qclr),     640'(0));
        chk("pready",   640'(apb.pready),  640'(1));
        chk("pslverr",  640'(apb.pslverr), 640'(0));
    endtask

    // Full setup+access transfer; outputs are sampled on the falling edge after the capturing edge.
    task automatic apb_xfer(input logic we, input logic [14:0] addr, input logic [31:0] data);
        logic [NMVU-1:0] es;
        int id, off;
        @(negedge clk);
        apb.psel = 1'b1; apb.pwrite = we; apb.penable = 1'b0; apb.paddr = addr; apb.pwdata = data;
        @(negedge clk);
        chk("start_setup", 640'(start), 640'(0));
        apb.penable = 1'b1;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        id  = int'(addr[14:12]);
        off = int'(addr[11:0]);
        es  = '0;
        if (we) begin
            model_write(id, off, data);
            if (off == 'h34) es[id] = 1'b1;
        end
        chk("start_pulse", 640'(start), 640'(es));
        check_all();
        @(negedge clk);
        chk("start_clr", 640'(start), 640'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout n_vec=%0d", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start", 640'(start), 640'(0));
        check_all();
        rst_n = 1'b1;

        apb_xfer(1'b1, 15'h2000, 32'h0000_01A5);
        chk("wbase_m2", 640'(wbase[2*BBWADDR +: BBWADDR]), 640'(9'h1A5));

        apb_xfer(1'b1, 15'h0032, 32'h0300_2082);
        chk("wprec_m0", 640'(wprec[0 +: 6]), 640'(2));
        chk("oprec_m0", 640'(oprec[0 +: 6]), 640'(2));
        chk("sign_m0",  640'({dsgn[0], wsgn[0]}), 640'(3));

        apb_xfer(1'b1, 15'h5034, 32'hE000_0010);
        chk("cnt_m5",   640'(cntdn[5*BCNTDWN +: BCNTDWN]), 640'(29'h10));
        chk("mul_m5",   640'({mulmode[5*2 +: 2], maxen[5]}), 640'(7));

        apb_xfer(1'b1, 15'h1028, 32'd7);
        apb_xfer(1'b1, 15'h102D, 32'd9);
        chk("slen3_m1", 640'(slen[(1*NLEN + 2)*BLENGTH +: BLENGTH]), 640'(7));
        chk("blen4_m1", 640'(blen[(1*NLEN + 3)*BLENGTH +: BLENGTH]), 640'(9));

        apb_xfer(1'b1, 15'h07FF, 32'hFFFF_FFFF);
        apb_xfer(1'b1, 15'h3033, 32'hFFFF_FFFF);
        apb_xfer(1'b0, 15'h3034, 32'hFFFF_FFFF);

        // Reset asserted over the capturing edge of a COMMAND write.
        @(negedge clk);
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
        apb.paddr = 15'h6034; apb.pwdata = 32'h2000_0005;
        @(negedge clk);
        apb.penable = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        model_reset();
        chk("rst_mid_start", 640'(start), 640'(0));
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_start2", 640'(start), 640'(0));

        for (int n = 0; n < 200; n++) begin
            logic [2:0]  id;
            logic [11:0] off;
            logic        we;
            id  = 3'($urandom_range(0, NMVU - 1));
            off = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(0, 12'hFFF))
                                              : 12'($urandom_range(0, 8'h4F));
            we  = ($urandom_range(0, 7) != 0);
            apb_xfer(we, {id, off}, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mvu_apb_cfg_regs.md
Name: mvu_apb_cfg_regs

Overview:
- APB slave that decodes CSR writes into the per-MVU configuration registers consumed by the MVU array (the MVU_CFG_INTERFACE signal set).
- Also generates the per-MVU single-cycle start pulse when a COMMAND register is written.
- Sits between the system APB fabric and the MVU top.
- Write-only, zero wait states, never signals an error.

Parameters:
- NMVU, 8, number of MVUs.
- BMVUA, 3, MVU index width.
- APB_ADDR_WIDTH, 15, equals BMVUA+12.
- APB_DATA_WIDTH, 32, APB data width.
- NJUMPS, 5, jump registers per stream.
- BBWADDR, 9; BBDADDR, 9; BSBANKA, 6; BBBANKA, 6: base address widths.
- BJUMP, 15; BLENGTH, 15: jump and length widths.
- BPREC, 6; BCNTDWN, 29; BQMSBIDX, 5; BSCALERB, 16: field widths.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  APB_ADDR_WIDTH  APB address
- pwdata  in  32  APB write data
- pready  out  1  tied 1
- pslverr  out  1  tied 0
- start  out  NMVU  one-cycle start pulse per MVU
- cfg_*  out  flattened per-MVU config registers; MVU i occupies slice [i*W +: W].
  - Base addresses: wbaseaddr, ibaseaddr, obaseaddr, ihpbaseaddr, ohpbaseaddr, sbaseaddr, bbaseaddr.
  - Jumps: wjump, ijump, sjump, bjump, ojump, hpjump (NJUMPS×BJUMP per MVU).
  - Lengths: wlength, ilength, slength, blength, olength, hplength (indices 1..4, each BLENGTH).
  - Precision and sign: wprecision, iprecision, oprecision, w_signed, d_signed.
  - Command fields: countdown, max_en, mul_mode(2).
  - Constant-zero outputs: max_clr, max_pool, quant_clr.
  - Other: quant_msbidx, scaler_b, shacc_load_sel(NJUMPS), zigzag_step_sel(NJUMPS), omvusel(NMVU), ohpmvusel, usescaler_mem, usebias_mem, usepooler4hpout, usehpadder.

Behaviour:
- Write strobe: wr = psel & penable & pwrite.
- Address decode: mvu_id = paddr[APB_ADDR_WIDTH-1:12]; CSR offset = paddr[11:0].
- All config registers are flops on clk. On a cycle with wr, the addressed field of MVU mvu_id loads from pwdata; it is visible on the next cycle.
- Reset: rst_n=0 clears every config register and start to 0.
- Ignored writes, no state change: unknown offsets, STATUS, and mvu_id >= NMVU.
- CSR offset map (shared package, byte offsets):
  - 0x00-0x04: W/I/S/B/O BASEPTR.
  - 0x05-0x09 WJUMP0-4; 0x0A-0x0E IJUMP0-4; 0x0F-0x13 SJUMP0-4; 0x14-0x18 BJUMP0-4; 0x19-0x1D OJUMP0-4.
  - 0x1E-0x21 WLENGTH1-4; 0x22-0x25 ILENGTH1-4; 0x26-0x29 SLENGTH1-4; 0x2A-0x2D BLENGTH1-4; 0x2E-0x31 OLENGTH1-4.
  - 0x32 PRECISION; 0x33 STATUS; 0x34 COMMAND; 0x35 QUANT; 0x36 SCALER; 0x37 CONFIG1.
  - 0x38 OMVUSEL; 0x39 IHPBASEADDR; 0x3A OHPBASEADDR; 0x3B OHPMVUSEL.
  - 0x3C-0x40 HPJUMP0-4; 0x41-0x44 HPLENGTH1-4.
  - 0x45 USESCALER_MEM; 0x46 USEBIAS_MEM; 0x47 USEPOOLER4HPOUT; 0x48 USEHPADDER.
- Field mapping (LSB-aligned, truncated to field width unless listed):
  - PRECISION: wprec=[5:0], iprec=[11:6], oprec=[17:12], w_signed=[24], d_signed=[25].
  - COMMAND: countdown=[28:0], max_en=[29], mul_mode=[31:30].
  - CONFIG1: shacc_load_sel=[4:0], zigzag_step_sel=[9:5].
  - Flag registers (OHPMVUSEL, USE*): bit 0.
  - Each length index writes its own slot, including SLENGTH/BLENGTH. HPLENGTH is BLENGTH wide.
- Start pulse:
  - A wr to COMMAND with valid mvu_id sets start[mvu_id]=1 for exactly the next cycle; all other bits are 0.
  - The config loads on the same edge, so the MVU sees the new countdown together with start.
  - start drops to 0 the following cycle.
  - A COMMAND rewrite while start is high re-pulses only after start returns low.
- max_clr, max_pool, quant_clr are constant 0.
- Reset mid-transfer: the write is lost and start stays 0.

Optional Feature:
- Macro: MVU_CSR_READBACK_EN.
- Defined: adds output prdata[31:0]. When psel & ~pwrite, prdata returns the addressed MVU's field, packed as written. STATUS returns {31'b0, start[mvu_id]}. Unknown or invalid addresses return 0. prdata is combinational.
- Undefined: no prdata port; reads complete with pready=1 and no side effects.

Decomposition:
- Package mvu_cfg_pkg holds:
  - the size parameters;
  - the mvu_csr_t enum with the offsets above;
  - bit-position constants for PRECISION, COMMAND and CONFIG1.
- One natural sub-module: mvu_start_gen (COMMAND detect and per-MVU start pulse), instantiated once.

Test Plan:
- Reset: hold rst_n=0 2 cycles -> all cfg_* and start read 0, pready=1, pslverr=0.
- Base addresses: write paddr=0x2000 (mvu 2, WBASEPTR), pwdata=0x1A5 -> wbaseaddr slice 2 = 0x1A5 next cycle; other MVUs unchanged.
- Precision: write PRECISION to mvu 0 with 0x0300_2082 -> wprec=2, iprec=2, oprec=2, w_signed=1, d_signed=1.
- Start pulse: write COMMAND to mvu 5 with 0xE000_0010 -> countdown=0x10, max_en=1, mul_mode=3; start=8'b0010_0000 for exactly one cycle.
- Lengths: write SLENGTH3=7 and BLENGTH4=9 to mvu 1 -> only slength[1][3]=7 and blength[1][4]=9 change.
- Ignored writes: write to offset 0x7FF, to STATUS, and with pwrite=0 -> no config change, no start.
